bbc_keyboard_scanner: RTL and testbench
=======================================

Name: bbc_keyboard_scanner

Overview:
- Sequences the BBC keyboard key matrix (columns 0-9, rows 0-7) for the system VIA.
- Two modes, as on the original machine:
  - Manual: the CPU selects a column and row and reads back one key bit.
  - Auto-scan: a column counter sweeps the matrix and raises a level interrupt (CA2) when any non-modifier key (rows 1-7) is down.
- Also stretches the BREAK key into a fixed-length reset pulse.
- Sits between the keyboard state source (CSR or PS/2 front end) and the VIA/addressable-latch logic.

Parameters:
- scan_divider, 16, number of enabled clock cycles spent on each column in auto-scan (minimum 1).
- num_columns, 10, columns scanned; the counter wraps from num_columns-1 to 0.
- reset_hold, 200, number of enabled cycles that reset_out is held after a BREAK press.

Ports:
- clk, input, 1, system clock (2MHz domain).
- clk__enable, input, 1, clock enable; all state holds when low.
- reset_n, input, 1, asynchronous active-low reset.
- keyboard__reset_pressed, input, 1, BREAK key down.
- keyboard__keys_down_cols_0_to_7, input, 64, key matrix; bit 8c+r is column c, row r.
- keyboard__keys_down_cols_8_to_9, input, 16, key matrix; bit 8(c-8)+r is column c, row r.
- keyboard_enable_n, input, 1, addressable latch bit 3; 0 selects auto-scan, 1 selects manual.
- column_select, input, 4, manual column (VIA PA3:0).
- row_select, input, 3, manual row (VIA PA6:4).
- int_ack, input, 1, clears interrupt_pending.
- key_pressed, output, 1, manual read result (VIA PA7).
- column_activity, output, 1, level: any of rows 1-7 down in the current auto-scan column (CA2).
- interrupt_pending, output, 1, sticky flag set by a rising edge of column_activity.
- scan_column, output, 4, current auto-scan column.
- reset_out, output, 1, stretched BREAK reset.

Behaviour:
- Decision of record: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: key_pressed=0, column_activity=0, interrupt_pending=0, scan_column=0, reset_out=0. Internal state: mode=MANUAL, divider counter=0, reset counter=0, previous reset_pressed=0.
- All registers update only on clk rising edges with clk__enable=1.
- Matrix lookup: columns 10-15 read all-zero, whatever the inputs.
- Mode FSM (2 states), evaluated every enabled cycle:
  - MANUAL -> AUTO_SCAN when keyboard_enable_n=0. On that transition scan_column loads column_select, or 0 if column_select >= num_columns, and the divider clears.
  - AUTO_SCAN -> MANUAL when keyboard_enable_n=1. scan_column freezes.
- MANUAL:
  - key_pressed <= matrix[column_select][row_select], registered: 1-cycle latency from select change.
  - column_activity <= 0.
- AUTO_SCAN:
  - The divider counts 0..scan_divider-1. On reaching terminal count it returns to 0 and scan_column advances, wrapping num_columns-1 -> 0.
  - column_activity <= OR of rows 1-7 of the column scan_column holds in that cycle (registered, 1-cycle latency).
  - Row 0 (SHIFT/CTRL/DIP switches) never contributes.
  - key_pressed <= matrix[scan_column][row_select].
- interrupt_pending:
  - Set on the cycle column_activity goes 0 -> 1.
  - Cleared by int_ack.
  - If a set and int_ack occur in the same cycle, the set wins.
  - Holds across mode changes.
- BREAK:
  - On a rising edge of keyboard__reset_pressed (compared with its registered previous value), the reset counter loads reset_hold and reset_out <= 1.
  - While the counter is nonzero it decrements each enabled cycle and reset_out stays 1. reset_out <= 0 on the cycle the counter reaches 0.
  - A new rising edge while counting reloads reset_hold (retrigger).
  - Holding BREAK down does not extend the pulse.
- Asynchronous reset mid-scan or mid-pulse: everything returns to reset values immediately. Scanning resumes from column 0 in MANUAL mode.

Test Plan:
- Manual read: keyboard_enable_n=1, bit 8*3+5 set, column_select=3, row_select=5 -> key_pressed=1 one enabled cycle later; changing to row_select=4 -> 0 next cycle.
- Column 9: cols_8_to_9 bit 15 set, column_select=9, row_select=7 -> key_pressed=1; column_select=12 -> key_pressed=0.
- Auto-scan wrap: scan_divider=2, column_select=8, drop keyboard_enable_n -> scan_column goes 8,8,9,9,0,0,1...
- Interrupt: only row 0 set in column 2 -> column_activity stays 0 through a full sweep. Then set row 1 of column 2 -> column_activity=1 for 2 cycles when scanning column 2 and interrupt_pending=1. Assert int_ack on the next rising edge of column_activity -> interrupt_pending stays 1.
- BREAK: reset_hold=200; pulse keyboard__reset_pressed for 1 cycle -> reset_out high for exactly 200 enabled cycles. A second press at cycle 150 -> 200 more cycles from that point. With clk__enable low for 10 cycles mid-pulse -> pulse is 10 cycles longer in wall-clock time.
- Asynchronous reset: assert reset_n=0 mid-pulse and mid-scan -> all outputs 0 immediately; after release the block is in MANUAL mode with scan_column=0.

Source files
------------

// File: rtl/bbc_keyboard_scanner.sv
// BBC keyboard matrix scanner: manual column/row read-back for the system VIA,
// free-running auto-scan with a column-activity (CA2) level and sticky
// interrupt flag, and BREAK-key stretching into a fixed-length reset pulse.
module bbc_keyboard_scanner #(
    parameter int unsigned scan_divider = 16,
    parameter int unsigned num_columns  = 10,
    parameter int unsigned reset_hold   = 200
) (
    input  logic        clk,
    input  logic        clk__enable,
    input  logic        reset_n,
    input  logic        keyboard__reset_pressed,
    input  logic [63:0] keyboard__keys_down_cols_0_to_7,
    input  logic [15:0] keyboard__keys_down_cols_8_to_9,
    input  logic        keyboard_enable_n,
    input  logic [3:0]  column_select,
    input  logic [2:0]  row_select,
    input  logic        int_ack,
    output logic        key_pressed,
    output logic        column_activity,
    output logic        interrupt_pending,
    output logic [3:0]  scan_column,
    output logic        reset_out
);

    localparam int unsigned DIV_W = (scan_divider > 1) ? $clog2(scan_divider) : 1;
    localparam int unsigned RST_W = (reset_hold > 0) ? $clog2(reset_hold + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(scan_divider - 1);
    localparam logic [3:0]       LAST_COL  = 4'(num_columns - 1);
    localparam logic [RST_W-1:0] HOLD_LOAD = RST_W'(reset_hold);
    localparam logic [RST_W-1:0] HOLD_ONE  = RST_W'(1);

    localparam logic MODE_MANUAL    = 1'b0;
    localparam logic MODE_AUTO_SCAN = 1'b1;

    logic             mode_q,     mode_d;
    logic [3:0]       scan_q,     scan_d;
    logic [DIV_W-1:0] div_q,      div_d;
    logic             kp_q,       kp_d;
    logic             act_q,      act_d;
    logic             pend_q,     pend_d;
    logic             brk_prev_q, brk_prev_d;
    logic [RST_W-1:0] rcnt_q,     rcnt_d;
    logic             rout_q,     rout_d;

    logic [7:0] manual_rows;
    logic [7:0] scan_rows;

    // Row byte of one matrix column; columns 10-15 are always empty.
    function automatic logic [7:0] column_rows(input logic [3:0]  col,
                                               input logic [63:0] cols_lo,
                                               input logic [15:0] cols_hi);
        logic [7:0] rows;
        rows = '0;
        if (col[3] == 1'b0)
            rows = cols_lo[{col[2:0], 3'b000} +: 8];
        else if (col[2:1] == 2'b00)
            rows = cols_hi[{col[0], 3'b000} +: 8];
        return rows;
    endfunction

    // Matrix lookups for the CPU-selected column and the auto-scan column.
    always_comb begin
        manual_rows = column_rows(column_select, keyboard__keys_down_cols_0_to_7,
                                  keyboard__keys_down_cols_8_to_9);
        scan_rows   = column_rows(scan_q, keyboard__keys_down_cols_0_to_7,
                                  keyboard__keys_down_cols_8_to_9);
    end

    // Next-state logic for the mode FSM, scan counter, read-back, interrupt and BREAK stretcher.
    always_comb begin
        mode_d     = mode_q;
        scan_d     = scan_q;
        div_d      = div_q;
        kp_d       = kp_q;
        act_d      = act_q;
        rcnt_d     = rcnt_q;
        rout_d     = rout_q;
        brk_prev_d = keyboard__reset_pressed;

        case (mode_q)
            MODE_MANUAL: begin
                kp_d  = manual_rows[row_select];
                act_d = 1'b0;
                if (!keyboard_enable_n) begin
                    mode_d = MODE_AUTO_SCAN;
                    scan_d = (column_select > LAST_COL) ? '0 : column_select;
                    div_d  = '0;
                end
            end
            default: begin
                kp_d  = scan_rows[row_select];
                // Row 0 carries SHIFT/CTRL/links and never signals activity.
                act_d = |scan_rows[7:1];
                if (keyboard_enable_n) begin
                    mode_d = MODE_MANUAL;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    scan_d = (scan_q == LAST_COL) ? '0 : scan_q + 4'd1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase

        // A new rising edge of activity beats a simultaneous acknowledge.
        pend_d = (act_d & ~act_q) | (pend_q & ~int_ack);

        if (keyboard__reset_pressed && !brk_prev_q) begin
            rcnt_d = HOLD_LOAD;
            rout_d = 1'b1;
        end else if (rcnt_q != '0) begin
            rcnt_d = rcnt_q - 1'b1;
            rout_d = (rcnt_q != HOLD_ONE);
        end
    end

    // State registers, advancing only on enabled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MODE_MANUAL;
            scan_q     <= '0;
            div_q      <= '0;
            kp_q       <= 1'b0;
            act_q      <= 1'b0;
            pend_q     <= 1'b0;
            brk_prev_q <= 1'b0;
            rcnt_q     <= '0;
            rout_q     <= 1'b0;
        end else if (clk__enable) begin
            mode_q     <= mode_d;
            scan_q     <= scan_d;
            div_q      <= div_d;
            kp_q       <= kp_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            brk_prev_q <= brk_prev_d;
            rcnt_q     <= rcnt_d;
            rout_q     <= rout_d;
        end
    end

    assign key_pressed       = kp_q;
    assign column_activity   = act_q;
    assign interrupt_pending = pend_q;
    assign scan_column       = scan_q;
    assign reset_out         = rout_q;

endmodule

// File: tb/tb_bbc_keyboard_scanner.sv
// Scoreboard bench for bbc_keyboard_scanner: the driver runs an abstract
// reference model and queues expected outputs; a monitor compares after each edge.
module tb_bbc_keyboard_scanner;

    localparam int SD = 2;
    localparam int NC = 10;
    localparam int RH = 200;

    logic        clk;
    logic        en;
    logic        reset_n;
    logic        brk;
    logic [63:0] cols07;
    logic [15:0] cols89;
    logic        en_n;
    logic [3:0]  csel;
    logic [2:0]  rsel;
    logic        ack;
    logic        key_pressed;
    logic        column_activity;
    logic        interrupt_pending;
    logic [3:0]  scan_column;
    logic        reset_out;

    bbc_keyboard_scanner #(
        .scan_divider(SD),
        .num_columns (NC),
        .reset_hold  (RH)
    ) dut (
        .clk                             (clk),
        .clk__enable                     (en),
        .reset_n                         (reset_n),
        .keyboard__reset_pressed         (brk),
        .keyboard__keys_down_cols_0_to_7 (cols07),
        .keyboard__keys_down_cols_8_to_9 (cols89),
        .keyboard_enable_n               (en_n),
        .column_select                   (csel),
        .row_select                      (rsel),
        .int_ack                         (ack),
        .key_pressed                     (key_pressed),
        .column_activity                 (column_activity),
        .interrupt_pending               (interrupt_pending),
        .scan_column                     (scan_column),
        .reset_out                       (reset_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit kp;
        bit act;
        bit pend;
        int col;
        bit rout;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: scan position derived from start column and time spent
    // scanning; the BREAK pulse derived from enabled cycles since the last press.
    bit m_auto;
    int m_start;
    int m_nauto;
    bit m_kp;
    bit m_act;
    bit m_pend;
    bit m_prev;
    bit m_have_edge;
    int m_edge_cyc;
    int m_ecyc;

    task automatic model_reset();
        m_auto = 0; m_start = 0; m_nauto = 0;
        m_kp = 0; m_act = 0; m_pend = 0; m_prev = 0;
        m_have_edge = 0; m_edge_cyc = 0; m_ecyc = 0;
    endtask

    function automatic bit key_at(int c, int r);
        if (c >= 10) return 1'b0;
        if (c < 8) return cols07[8 * c + r];
        return cols89[8 * (c - 8) + r];
    endfunction

    function automatic int cur_col();
        return (m_start + m_nauto / SD) % NC;
    endfunction

    task automatic chk(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // One clock: advance the model on current inputs, queue the expectation, step.
    task automatic cycle();
        int   cc;
        bit   kp_n;
        bit   act_n;
        exp_t e;
        if (en) begin
            cc = cur_col();
            act_n = 0;
            if (!m_auto) begin
                kp_n = key_at(int'(csel), int'(rsel));
                if (!en_n) begin
                    m_auto  = 1;
                    m_start = (int'(csel) < NC) ? int'(csel) : 0;
                    m_nauto = 0;
                end
            end else begin
                kp_n = key_at(cc, int'(rsel));
                for (int r = 1; r < 8; r++) act_n |= key_at(cc, r);
                if (en_n) begin
                    m_auto  = 0;
                    m_start = cc;
                    m_nauto = 0;
                end else begin
                    m_nauto++;
                end
            end
            if (act_n && !m_act) m_pend = 1;
            else if (ack)        m_pend = 0;
            m_act = act_n;
            m_kp  = kp_n;
            m_ecyc++;
            if (brk && !m_prev) begin
                m_have_edge = 1;
                m_edge_cyc  = m_ecyc;
            end
            m_prev = brk;
        end
        e.kp   = m_kp;
        e.act  = m_act;
        e.pend = m_pend;
        e.col  = cur_col();
        e.rout = m_have_edge && ((m_ecyc - m_edge_cyc) < RH);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic async_reset_check();
        #2 reset_n = 1'b0;
        #1;
        chk("rst key_pressed",       int'(key_pressed),       0);
        chk("rst column_activity",   int'(column_activity),   0);
        chk("rst interrupt_pending", int'(interrupt_pending), 0);
        chk("rst scan_column",       int'(scan_column),       0);
        chk("rst reset_out",         int'(reset_out),         0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: compare every edge for which the driver queued an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("key_pressed",       int'(key_pressed),       int'(e.kp));
                chk("column_activity",   int'(column_activity),   int'(e.act));
                chk("interrupt_pending", int'(interrupt_pending), int'(e.pend));
                chk("scan_column",       int'(scan_column),       e.col);
                chk("reset_out",         int'(reset_out),         int'(e.rout));
            end
        end
    end

    initial begin
        int idx;
        reset_n = 1'b1; en = 1'b1; brk = 1'b0; cols07 = '0; cols89 = '0;
        en_n = 1'b1; csel = '0; rsel = '0; ack = 1'b0;
        model_reset();
        async_reset_check();

        // Manual read, latency and row change.
        cols07[8 * 3 + 5] = 1'b1; csel = 4'd3; rsel = 3'd5;
        run(2);
        rsel = 3'd4;
        run(2);
        // Column 9 and out-of-range column.
        cols89[15] = 1'b1; csel = 4'd9; rsel = 3'd7;
        run(2);
        csel = 4'd12;
        run(2);

        // Auto-scan wrap from column 8.
        csel = 4'd8; en_n = 1'b0;
        run(12);
        en_n = 1'b1;
        run(3);

        // Row 0 only in column 2, then row 1; ack held through the next rise.
        cols07 = '0; cols89 = '0;
        cols07[8 * 2 + 0] = 1'b1;
        csel = 4'd0; en_n = 1'b0;
        run(25);
        cols07[8 * 2 + 1] = 1'b1;
        run(25);
        ack = 1'b1;
        run(25);
        ack = 1'b0;

        // BREAK: single press, retrigger at 150, enable gap mid-pulse.
        en_n = 1'b1;
        brk = 1'b1; cycle(); brk = 1'b0;
        run(149);
        brk = 1'b1; cycle(); brk = 1'b0;
        run(205);
        brk = 1'b1; run(3); brk = 1'b0;
        run(50);
        en = 1'b0; run(10); en = 1'b1;
        run(160);

        // Asynchronous reset mid-pulse and mid-scan.
        cols07[8 * 5 + 3] = 1'b1;
        csel = 4'd4; en_n = 1'b0;
        brk = 1'b1; cycle(); brk = 1'b0;
        run(9);
        async_reset_check();
        en_n = 1'b1; csel = 4'd5; rsel = 3'd3;
        run(4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 59) == 0) en_n = ~en_n;
            csel = 4'($urandom_range(0, 15));
            rsel = 3'($urandom_range(0, 7));
            ack  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) brk = 1'b1;
            else if ($urandom_range(0, 2) == 0) brk = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                idx = int'($urandom_range(0, 63));
                cols07[idx] = ~cols07[idx];
            end
            if ($urandom_range(0, 29) == 0) begin
                idx = int'($urandom_range(0, 15));
                cols89[idx] = ~cols89[idx];
            end
            if ($urandom_range(0, 499) == 0) begin
                cols07 = '0;
                cols89 = '0;
            end
            cycle();
            if (i == 2000) async_reset_check();
        end

        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
